// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM round-robin arbiter.
// Read-ownership tracking is sized for the largest supported requester count.
package dpram_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] own;
    } rd_track_t;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/dpram_rr_arbiter_rr_pick.sv
// Circular find-first: returns the first set bit of req scanning start, start+1, ...
// wrapping modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(start) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter sharing a read-first dual-port RAM among NUM_REQ requesters,
// granting up to one request per RAM port per cycle and routing read data back.
module dpram_rr_arbiter
    import dpram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DEPTH   = 8,
    parameter  int WIDTH   = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_we,
    input  logic [NUM_REQ*AW-1:0]    req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [NUM_REQ*WIDTH-1:0] rsp_rdata,
    output logic                     ram_w_en_a,
    output logic                     ram_w_en_b,
    output logic [AW-1:0]            ram_addr_a,
    output logic [AW-1:0]            ram_addr_b,
    output logic [WIDTH-1:0]         ram_data_in_a,
    output logic [WIDTH-1:0]         ram_data_in_b,
    input  logic [WIDTH-1:0]         ram_data_out_a,
    input  logic [WIDTH-1:0]         ram_data_out_b
);

    logic [AW-1:0]      addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]   wdata_arr [NUM_REQ];
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      idx_a, idx_b, start_b;
    logic               found_a, found_b;
    logic [NUM_REQ-1:0] mask_b;
    rd_track_t          trk_a, trk_b;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*AW +: AW];
            wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
        end
    end

    rr_pick #(.N(NUM_REQ)) u_pick_a (
        .req   (req_valid),
        .start (rr_ptr),
        .found (found_a),
        .idx   (idx_a)
    );

    assign start_b = IW'(wrap_inc(int'(idx_a), NUM_REQ));

    // Port B may not touch Pick 1's address unless both accesses are reads.
    always_comb begin
        mask_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_b[i] = found_a && req_valid[i] && (IW'(i) != idx_a) &&
                        !((addr_arr[i] == addr_arr[idx_a]) && (req_we[i] || req_we[idx_a]));
        end
    end

    rr_pick #(.N(NUM_REQ)) u_pick_b (
        .req   (mask_b),
        .start (start_b),
        .found (found_b),
        .idx   (idx_b)
    );

    // Grants and RAM controls are forced idle while reset is asserted.
    always_comb begin
        req_ready     = '0;
        ram_w_en_a    = 1'b0;
        ram_addr_a    = '0;
        ram_data_in_a = '0;
        ram_w_en_b    = 1'b0;
        ram_addr_b    = '0;
        ram_data_in_b = '0;
        if (rst_n) begin
            if (found_a) begin
                req_ready[idx_a] = 1'b1;
                ram_w_en_a       = req_we[idx_a];
                ram_addr_a       = addr_arr[idx_a];
                if (req_we[idx_a]) ram_data_in_a = wdata_arr[idx_a];
            end
            if (found_b) begin
                req_ready[idx_b] = 1'b1;
                ram_w_en_b       = req_we[idx_b];
                ram_addr_b       = addr_arr[idx_b];
                if (req_we[idx_b]) ram_data_in_b = wdata_arr[idx_b];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            trk_a  <= '0;
            trk_b  <= '0;
        end else begin
            trk_a.vld <= found_a && !req_we[idx_a];
            trk_a.own <= IDX_W'(idx_a);
            trk_b.vld <= found_b && !req_we[idx_b];
            trk_b.own <= IDX_W'(idx_b);
            if (found_b)      rr_ptr <= IW'(wrap_inc(int'(idx_b), NUM_REQ));
            else if (found_a) rr_ptr <= start_b;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (trk_a.vld && (trk_a.own == IDX_W'(i))) begin
                rsp_valid[i]                 = 1'b1;
                rsp_rdata[i*WIDTH +: WIDTH] = ram_data_out_a;
            end else if (trk_b.vld && (trk_b.own == IDX_W'(i))) begin
                rsp_valid[i]                 = 1'b1;
                rsp_rdata[i*WIDTH +: WIDTH] = ram_data_out_b;
            end
        end
    end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Directed bench for dpram_rr_arbiter with a behavioural read-first dual-port RAM
// (NUM_REQ = 4, DEPTH = 8, WIDTH = 8).
module tb_dpram_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_we = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        ram_w_en_a, ram_w_en_b;
    logic [2:0]  ram_addr_a, ram_addr_b;
    logic [7:0]  ram_data_in_a, ram_data_in_b;
    logic [7:0]  ram_data_out_a, ram_data_out_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dpram_rr_arbiter #(.NUM_REQ(4), .DEPTH(8), .WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .ram_w_en_a     (ram_w_en_a),
        .ram_w_en_b     (ram_w_en_b),
        .ram_addr_a     (ram_addr_a),
        .ram_addr_b     (ram_addr_b),
        .ram_data_in_a  (ram_data_in_a),
        .ram_data_in_b  (ram_data_in_b),
        .ram_data_out_a (ram_data_out_a),
        .ram_data_out_b (ram_data_out_b)
    );

    // Read-first dual-port RAM, preloaded so word i holds 0x10 + i.
    logic [7:0] mem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    always @(posedge clk) begin
        if (ram_w_en_a) mem[ram_addr_a] <= ram_data_in_a;
        if (ram_w_en_b) mem[ram_addr_b] <= ram_data_in_b;
        ram_data_out_a <= mem[ram_addr_a];
        ram_data_out_b <= mem[ram_addr_b];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] w,
                         input logic [11:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [1:0]  ptr;
        logic [3:0]  ready;
        logic        wa;
        logic [2:0]  aa;
        logic [7:0]  da;
        logic        wb;
        logic [2:0]  ab;
        logic [7:0]  db;
        logic [3:0]  rv;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        // valid, we, addr{r3,r2,r1,r0}, wdata, ptr, ready, wa,aa,da, wb,ab,db, rsp_valid, rsp_rdata
        vecs[0]  = '{4'b0000, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 32'h0,        2'd0, 4'b0000, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 4'b0000, 32'h0};
        vecs[1]  = '{4'b0001, 4'b0001, {3'd0,3'd0,3'd0,3'd3}, 32'h000000A5, 2'd0, 4'b0001, 1'b1,3'd3,8'hA5, 1'b0,3'd0,8'h00, 4'b0000, 32'h0};
        vecs[2]  = '{4'b0001, 4'b0000, {3'd0,3'd0,3'd0,3'd3}, 32'h0,        2'd1, 4'b0001, 1'b0,3'd3,8'h00, 1'b0,3'd0,8'h00, 4'b0000, 32'h0};
        vecs[3]  = '{4'b0000, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 32'h0,        2'd1, 4'b0000, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 4'b0001, 32'h000000A5};
        vecs[4]  = '{4'b1000, 4'b0000, {3'd7,3'd0,3'd0,3'd0}, 32'h0,        2'd1, 4'b1000, 1'b0,3'd7,8'h00, 1'b0,3'd0,8'h00, 4'b0000, 32'h0};
        vecs[5]  = '{4'b1111, 4'b0000, {3'd4,3'd2,3'd1,3'd0}, 32'h0,        2'd0, 4'b0011, 1'b0,3'd0,8'h00, 1'b0,3'd1,8'h00, 4'b1000, 32'h17000000};
        vecs[6]  = '{4'b1100, 4'b0000, {3'd4,3'd2,3'd1,3'd0}, 32'h0,        2'd2, 4'b1100, 1'b0,3'd2,8'h00, 1'b0,3'd4,8'h00, 4'b0011, 32'h00001110};
        vecs[7]  = '{4'b0011, 4'b0001, {3'd0,3'd0,3'd5,3'd5}, 32'h0000003C, 2'd0, 4'b0001, 1'b1,3'd5,8'h3C, 1'b0,3'd0,8'h00, 4'b1100, 32'h14120000};
        vecs[8]  = '{4'b0010, 4'b0000, {3'd0,3'd0,3'd5,3'd0}, 32'h0,        2'd1, 4'b0010, 1'b0,3'd5,8'h00, 1'b0,3'd0,8'h00, 4'b0000, 32'h0};
        vecs[9]  = '{4'b0001, 4'b0000, {3'd0,3'd0,3'd0,3'd6}, 32'h0,        2'd2, 4'b0001, 1'b0,3'd6,8'h00, 1'b0,3'd0,8'h00, 4'b0010, 32'h00003C00};
        vecs[10] = '{4'b0110, 4'b0110, {3'd0,3'd6,3'd6,3'd0}, 32'h00221100, 2'd1, 4'b0010, 1'b1,3'd6,8'h11, 1'b0,3'd0,8'h00, 4'b0001, 32'h00000016};
        vecs[11] = '{4'b0100, 4'b0100, {3'd0,3'd6,3'd0,3'd0}, 32'h00220000, 2'd2, 4'b0100, 1'b1,3'd6,8'h22, 1'b0,3'd0,8'h00, 4'b0000, 32'h0};
        vecs[12] = '{4'b1000, 4'b0000, {3'd6,3'd0,3'd0,3'd0}, 32'h0,        2'd3, 4'b1000, 1'b0,3'd6,8'h00, 1'b0,3'd0,8'h00, 4'b0000, 32'h0};
        vecs[13] = '{4'b0000, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 32'h0,        2'd0, 4'b0000, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 4'b1000, 32'h22000000};
        vecs[14] = '{4'b0011, 4'b0000, {3'd0,3'd0,3'd3,3'd3}, 32'h0,        2'd0, 4'b0011, 1'b0,3'd3,8'h00, 1'b0,3'd3,8'h00, 4'b0000, 32'h0};
        vecs[15] = '{4'b0000, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 32'h0,        2'd2, 4'b0000, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 4'b0011, 32'h0000A5A5};
        vecs[16] = '{4'b1001, 4'b0000, {3'd1,3'd0,3'd0,3'd2}, 32'h0,        2'd2, 4'b1001, 1'b0,3'd1,8'h00, 1'b0,3'd2,8'h00, 4'b0000, 32'h0};
        vecs[17] = '{4'b0000, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 32'h0,        2'd1, 4'b0000, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 4'b1001, 32'h11000012};
        vecs[18] = '{4'b0110, 4'b0100, {3'd0,3'd7,3'd0,3'd0}, 32'h005A0000, 2'd1, 4'b0110, 1'b0,3'd0,8'h00, 1'b1,3'd7,8'h5A, 4'b0000, 32'h0};
        vecs[19] = '{4'b0000, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 32'h0,        2'd3, 4'b0000, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 4'b0010, 32'h00001000};

        // Reset state, with a write pending that must not reach the RAM.
        drive(4'b0001, 4'b0001, {3'd0,3'd0,3'd0,3'd2}, 32'h000000EE);
        repeat (2) @(negedge clk);
        check("rst_ready",  req_ready, 4'b0000);
        check("rst_wen",    {ram_w_en_a, ram_w_en_b}, 2'b00);
        check("rst_addr",   {ram_addr_a, ram_addr_b, ram_data_in_a, ram_data_in_b}, 22'h0);
        check("rst_rsp",    {rsp_valid, rsp_rdata}, 36'h0);
        check("rst_ptr",    dut.rr_ptr, 2'd0);
        drive(4'b0000, 4'b0000, 12'h0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].valid, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            @(negedge clk);
            check($sformatf("v%0d_ptr", v),   dut.rr_ptr, vecs[v].ptr);
            check($sformatf("v%0d_ready", v), req_ready, vecs[v].ready);
            check($sformatf("v%0d_porta", v), {ram_w_en_a, ram_addr_a, ram_data_in_a},
                  {vecs[v].wa, vecs[v].aa, vecs[v].da});
            check($sformatf("v%0d_portb", v), {ram_w_en_b, ram_addr_b, ram_data_in_b},
                  {vecs[v].wb, vecs[v].ab, vecs[v].db});
            check($sformatf("v%0d_rsp", v),   {rsp_valid, rsp_rdata}, {vecs[v].rv, vecs[v].rd});
            @(posedge clk);
            #1;
        end
        check("mem7_after_b_write", mem[7], 8'h5A);

        // Read granted, then reset pulsed before the edge that would capture it.
        drive(4'b0001, 4'b0000, {3'd0,3'd0,3'd0,3'd3}, 32'h0);
        @(negedge clk);
        check("mid_rst_grant", req_ready, 4'b0001);
        rst_n = 1'b0;
        drive(4'b0011, 4'b0010, {3'd0,3'd0,3'd4,3'd3}, 32'h0000EE00);
        #1;
        check("mid_rst_ready", req_ready, 4'b0000);
        check("mid_rst_wen",   {ram_w_en_a, ram_w_en_b}, 2'b00);
        @(posedge clk);
        #1;
        check("mid_rst_rsp",   rsp_valid, 4'b0000);
        check("mid_rst_ptr",   dut.rr_ptr, 2'd0);
        check("mid_rst_wen2",  {ram_w_en_a, ram_w_en_b}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 4'b0000, 12'h0, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_rsp",  rsp_valid, 4'b0000);
        drive(4'b0001, 4'b0000, {3'd0,3'd0,3'd0,3'd4}, 32'h0);
        @(posedge clk);
        #1;
        drive(4'b0000, 4'b0000, 12'h0, 32'h0);
        @(negedge clk);
        check("post_rst_mem4", {rsp_valid, rsp_rdata}, {4'b0001, 32'h00000014});
        @(posedge clk);
        #1;

        // req0 and req2 continuously reading; both served every cycle.
        for (int c = 0; c < 20; c++) begin
            drive(4'b0101, 4'b0000, {3'd0,3'd2,3'd0,3'd0}, 32'h0);
            @(negedge clk);
            check($sformatf("pair%0d_ready", c), req_ready, 4'b0101);
            if (c > 0)
                check($sformatf("pair%0d_rsp", c), {rsp_valid, rsp_rdata}, {4'b0101, 32'h00120010});
            @(posedge clk);
            #1;
        end

        // req3 joins: grants rotate 2+3, 0+2, 3+0 and nobody waits more than one cycle.
        begin
            logic [3:0] pat [3];
            int         wait_cnt [4];
            pat[0] = 4'b1100;
            pat[1] = 4'b0101;
            pat[2] = 4'b1001;
            for (int r = 0; r < 4; r++) wait_cnt[r] = 0;
            for (int c = 0; c < 9; c++) begin
                drive(4'b1101, 4'b0000, {3'd5,3'd2,3'd0,3'd0}, 32'h0);
                @(negedge clk);
                check($sformatf("trio%0d_ready", c), req_ready, pat[c % 3]);
                for (int r = 0; r < 4; r++) begin
                    if (r != 1) begin
                        wait_cnt[r] = req_ready[r] ? 0 : wait_cnt[r] + 1;
                        check($sformatf("trio%0d_starve_r%0d", c, r), wait_cnt[r] > 1, 1'b0);
                    end
                end
                @(posedge clk);
                #1;
            end
        end

        drive(4'b0000, 4'b0000, 12'h0, 32'h0);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
